uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Arbitrates two byte-stream requesters onto the single UART_TX frame engine and sequences
//  1- or 2-byte messages into back-to-back Data_Valid/P_DATA frames, tracking UART_TX busy.
//  Requester 0 carries ALU results; requester 1 carries register-file read data.
//  Sits in the UART TX clock domain; requests arrive already synchronised to CLK.
// PARAMETERS
//  DATA_WIDTH   8   UART payload width (bits per frame)
//  TIMEOUT_CYC  16  cycles allowed for tx_busy to rise after tx_data_valid (TX_TIMEOUT_EN only)
// PORTS
//  CLK           in   1             clock; every flop is on its rising edge
//  RST           in   1             synchronous reset, active-high
//  req_valid     in   2             per-requester request; held high until its req_ack
//  req_two       in   2             per-requester length: 1 = two frames, 0 = one frame
//  req0_data     in   2*DATA_WIDTH  requester 0 payload; low byte sent first
//  req1_data     in   2*DATA_WIDTH  requester 1 payload; low byte sent first
//  req_ack       out  2             one-cycle pulse: payload captured, requester may drop valid
//  tx_busy       in   1             busy from UART_TX
//  tx_data_valid out  1             Data_Valid to UART_TX, one-cycle pulse per frame
//  tx_p_data     out  DATA_WIDTH    P_DATA to UART_TX
//  sched_busy    out  1             high in every state except IDLE
//  err_timeout   out  1             sticky timeout flag; cleared only by RST
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr_last=1 (requester 0 wins the first tie); byte_cnt=0.
//  FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
//   IDLE: when any req_valid=1 and tx_busy=0, grant (round-robin: if both valid, grant
//     ~rr_last; else grant the valid one). Same cycle: capture payload and req_two into a
//     holding register, pulse req_ack[grant], set rr_last=grant, byte_cnt=0 -> ISSUE.
//     If tx_busy=1, stay in IDLE; no grant and no ack.
//   ISSUE: tx_data_valid=1 for exactly this cycle -> WAIT_HI.
//   WAIT_HI: stay until tx_busy=1 -> WAIT_LO.
//   WAIT_LO: stay until tx_busy=0. Then if req_two captured and byte_cnt=0: byte_cnt=1,
//     -> ISSUE; else -> IDLE.
//  tx_p_data: registered output, selected from the holding register by byte_cnt (0: low
//   byte, 1: high byte). It is valid in the ISSUE cycle and held stable until the state
//   leaves WAIT_LO, because UART_TX samples P_DATA late for parity. In IDLE it keeps its
//   last value.
//  Latency: grant in cycle N (req_ack); tx_data_valid in N+1. The next grant is possible
//   in the first cycle after tx_busy falls on the last byte.
//  Payload capture happens only at grant. Data changes while a frame is in flight are
//   ignored. A req_valid that drops before its ack is simply not served.
//  Simultaneous events: a new request arriving while the FSM is not in IDLE waits; no ack
//   is issued until the return to IDLE. In IDLE, only one ack is issued per cycle.
//  Round-robin fairness: a requester held continuously valid is served at most once before
//   the other valid requester is served.
//  RST mid-message: FSM returns to IDLE; the remaining byte is dropped; no retry. The UART
//   owner resets UART_TX together with this block.
// CONFIGURATION
//  TX_TIMEOUT_EN defined:
//   - A counter starts in ISSUE and runs in WAIT_HI.
//   - If tx_busy is still 0 after TIMEOUT_CYC cycles in WAIT_HI: set err_timeout=1, drop
//     the rest of the message, go to IDLE.
//  TX_TIMEOUT_EN undefined:
//   - No counter is built; WAIT_HI waits indefinitely.
//   - err_timeout is tied to 0.
// TESTING
//  1. Reset: RST=1 for 2 cycles -> all outputs 0, sched_busy=0.
//  2. Single 1-byte request: req_valid=2'b10, req1_data=16'h00A5, req_two=0, with a
//     UART_TX model (busy 1 cycle after tx_data_valid, held 11 cycles) -> req_ack=2'b10
//     for 1 cycle; one tx_data_valid pulse with tx_p_data=8'hA5; back to IDLE.
//  3. 2-byte request: req0_data=16'h3C7E, req_two[0]=1 -> exactly two frames, 8'h7E then
//     8'h3C; second tx_data_valid comes 1 cycle after busy falls; tx_p_data stable in each
//     frame.
//  4. Both requesters continuously valid, one byte each -> acks alternate 01,10,01,10;
//     the first ack after reset is to requester 0.
//  5. Requester 1 raises valid during requester 0's frame -> no ack until IDLE; then
//     req_ack=2'b10 on the cycle after busy falls.
//  6. TX_TIMEOUT_EN, TIMEOUT_CYC=16, tx_busy tied 0 -> err_timeout=1 after 16 cycles in
//     WAIT_HI; FSM in IDLE; next request still served. Without the macro: FSM stays in
//     WAIT_HI and err_timeout=0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-requester round-robin scheduler feeding 1/2-byte messages to UART_TX
// Optional TX_TIMEOUT_EN: watchdog on tx_busy rising after each frame, sticky err_timeout.
module uart_tx_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_two,
    input  logic [2*DATA_WIDTH-1:0] req0_data,
    input  logic [2*DATA_WIDTH-1:0] req1_data,
    output logic [1:0]              req_ack,
    input  logic                    tx_busy,
    output logic                    tx_data_valid,
    output logic [DATA_WIDTH-1:0]   tx_p_data,
    output logic                    sched_busy,
    output logic                    err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t                  state;
    logic                    rr_last;
    logic                    byte_cnt;
    logic                    hold_two;
    logic [DATA_WIDTH-1:0]   hold_hi;
    logic                    grant_en;
    logic                    grant_idx;
    logic [2*DATA_WIDTH-1:0] grant_data;
    logic                    timeout_hit;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    // The ack must land in the same cycle the payload is captured, so the grant is decoded here.
    assign grant_en   = !RST && (state == IDLE) && (|req_valid) && !tx_busy;
    assign grant_idx  = (&req_valid) ? ~rr_last : req_valid[1];
    assign grant_data = grant_idx ? req1_data : req0_data;
    assign req_ack    = grant_en ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

`ifdef TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    assign timeout_hit = (state == WAIT_HI) && !tx_busy && (tmo_cnt == CW'(TIMEOUT_CYC - 1));
    assign err_timeout = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT_HI && !tx_busy)
                tmo_cnt <= tmo_cnt + CW'(1);
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            rr_last       <= 1'b1;
            byte_cnt      <= 1'b0;
            hold_two      <= 1'b0;
            hold_hi       <= '0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            sched_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        hold_hi       <= grant_data[2*DATA_WIDTH-1:DATA_WIDTH];
                        hold_two      <= req_two[grant_idx];
                        rr_last       <= grant_idx;
                        byte_cnt      <= 1'b0;
                        tx_p_data     <= grant_data[DATA_WIDTH-1:0];
                        tx_data_valid <= 1'b1;
                        sched_busy    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_data_valid <= 1'b0;
                    state         <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (timeout_hit) begin
                        sched_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WAIT_LO: begin
                    // P_DATA must stay put until here: UART_TX samples it late for parity.
                    if (!tx_busy) begin
                        if (hold_two && !byte_cnt) begin
                            byte_cnt      <= 1'b1;
                            tx_p_data     <= hold_hi;
                            tx_data_valid <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            sched_busy <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench for uart_tx_scheduler with a UART_TX busy model
module tb_uart_tx_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req_valid;
    logic [1:0]  req_two;
    logic [15:0] req0_data;
    logic [15:0] req1_data;
    logic [1:0]  req_ack;
    logic        tx_busy;
    logic        tx_data_valid;
    logic [7:0]  tx_p_data;
    logic        sched_busy;
    logic        err_timeout;

    logic model_busy = 1'b0;
    logic hold_busy  = 1'b0;
    logic model_en   = 1'b1;
    assign tx_busy = model_busy | hold_busy;

    uart_tx_scheduler #(.DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_two(req_two),
        .req0_data(req0_data), .req1_data(req1_data), .req_ack(req_ack),
        .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data),
        .sched_busy(sched_busy), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // UART_TX model: busy rises one cycle after Data_Valid and is held for 11 cycles.
    int left = 0;
    bit pend = 1'b0;
    always @(negedge CLK) begin
        if (RST || !model_en) begin
            model_busy = 1'b0;
            left       = 0;
            pend       = 1'b0;
        end else begin
            if (left > 0) begin
                left--;
                if (left == 0) model_busy = 1'b0;
            end
            if (pend) begin
                model_busy = 1'b1;
                left       = 11;
                pend       = 1'b0;
            end
            if (tx_data_valid) pend = 1'b1;
        end
    end

    logic [1:0] ack_q[$];
    int         ack_cyc[$];
    logic [7:0] frm_q[$];
    int         frm_cyc[$];
    logic [7:0] last_pd = 8'h00;
    int         stab_err = 0;

    always @(negedge CLK) begin
        #1;
        if (!RST) begin
            if (req_ack != 2'b00) begin
                ack_q.push_back(req_ack);
                ack_cyc.push_back(cyc);
            end
            if (tx_data_valid) begin
                frm_q.push_back(tx_p_data);
                frm_cyc.push_back(cyc);
                last_pd = tx_p_data;
            end else if (sched_busy && tx_p_data !== last_pd) begin
                stab_err++;
            end
        end
    end

    task automatic wait_acks(input int n, input string tag);
        int k = 0;
        while (ack_q.size() < n && k < 300) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_ack_seen"}, 32'(ack_q.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        repeat (2) @(negedge CLK);
        while ((sched_busy || tx_busy) && k < 300) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_idle"}, 32'({sched_busy, tx_busy}), 0);
    endtask

    int a, f, ak, k;

    initial begin
        RST = 1'b1; req_valid = 2'b11; req_two = 2'b00; req0_data = '0; req1_data = '0;
        repeat (2) @(negedge CLK);
        check("rst_ack", 32'(req_ack), 0);
        check("rst_dv", 32'(tx_data_valid), 0);
        check("rst_pdata", 32'(tx_p_data), 0);
        check("rst_sched_busy", 32'(sched_busy), 0);
        check("rst_err", 32'(err_timeout), 0);
        req_valid = 2'b00; RST = 1'b0;

        // both requesters held valid: 01,10,01,10
        @(negedge CLK);
        req0_data = 16'h0011; req1_data = 16'h0022; req_two = 2'b00; req_valid = 2'b11;
        wait_acks(4, "rr");
        req_valid = 2'b00;
        wait_idle("rr");
        check("rr_ack0", 32'(ack_q[0]), 'h1);
        check("rr_ack1", 32'(ack_q[1]), 'h2);
        check("rr_ack2", 32'(ack_q[2]), 'h1);
        check("rr_ack3", 32'(ack_q[3]), 'h2);
        check("rr_frm0", 32'(frm_q[0]), 'h11);
        check("rr_frm1", 32'(frm_q[1]), 'h22);
        check("rr_frm3", 32'(frm_q[3]), 'h22);
        check("rr_dv_latency", 32'(frm_cyc[0] - ack_cyc[0]), 1);
        check("rr_ack_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 14);

        // single byte from requester 1
        a = ack_q.size(); f = frm_q.size();
        @(negedge CLK);
        req1_data = 16'h00A5; req_two = 2'b00; req_valid = 2'b10;
        wait_acks(a + 1, "single");
        req_valid = 2'b00;
        wait_idle("single");
        check("single_ack", 32'(ack_q[a]), 'h2);
        check("single_ack_count", 32'(ack_q.size() - a), 1);
        check("single_frm_count", 32'(frm_q.size() - f), 1);
        check("single_frm", 32'(frm_q[f]), 'hA5);

        // two bytes from requester 0, low byte first
        a = ack_q.size(); f = frm_q.size();
        @(negedge CLK);
        req0_data = 16'h3C7E; req_two = 2'b01; req_valid = 2'b01;
        wait_acks(a + 1, "two");
        req_valid = 2'b00;
        wait_idle("two");
        check("two_frm_count", 32'(frm_q.size() - f), 2);
        check("two_frm_lo", 32'(frm_q[f]), 'h7E);
        check("two_frm_hi", 32'(frm_q[f+1]), 'h3C);
        check("two_dv_gap", 32'(frm_cyc[f+1] - frm_cyc[f]), 13);
        check("pdata_stable", 32'(stab_err), 0);

        // requester 1 arrives mid-frame and waits for IDLE
        a = ack_q.size(); f = frm_q.size();
        @(negedge CLK);
        req0_data = 16'h0055; req_two = 2'b00; req_valid = 2'b01;
        wait_acks(a + 1, "late0");
        req_valid = 2'b00;
        repeat (3) @(negedge CLK);
        req1_data = 16'h0066; req_valid = 2'b10;
        wait_acks(a + 2, "late1");
        req_valid = 2'b00;
        wait_idle("late");
        check("late_ack", 32'(ack_q[a+1]), 'h2);
        check("late_ack_cycle", 32'(ack_cyc[a+1] - ack_cyc[a]), 14);
        check("late_frm", 32'(frm_q[f+1]), 'h66);

        // tx_busy high while IDLE blocks the grant
        a = ack_q.size(); f = frm_q.size();
        @(negedge CLK);
        hold_busy = 1'b1; req0_data = 16'h0099; req_valid = 2'b01;
        repeat (6) @(negedge CLK);
        check("busy_idle_no_ack", 32'(ack_q.size() - a), 0);
        hold_busy = 1'b0;
        wait_acks(a + 1, "busy_idle");
        req_valid = 2'b00;
        wait_idle("busy_idle");
        check("busy_idle_frm", 32'(frm_q[f]), 'h99);

        // reset mid-message drops the second byte
        a = ack_q.size(); f = frm_q.size();
        @(negedge CLK);
        req0_data = 16'hBEEF; req_two = 2'b01; req_valid = 2'b01;
        wait_acks(a + 1, "midrst");
        req_valid = 2'b00;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("midrst_sched_busy", 32'(sched_busy), 0);
        check("midrst_pdata", 32'(tx_p_data), 0);
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        check("midrst_frm_count", 32'(frm_q.size() - f), 1);
        check("midrst_frm", 32'(frm_q[f]), 'hEF);

        // UART_TX never goes busy
        a = ack_q.size(); f = frm_q.size();
        @(negedge CLK);
        model_en = 1'b0; req_two = 2'b00; req0_data = 16'h0077; req_valid = 2'b01;
        wait_acks(a + 1, "tmo");
        req_valid = 2'b00;
        ak = ack_cyc[a];
        k = 0;
        while (cyc < ak + 17 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check("tmo_before_err", 32'(err_timeout), 0);
        check("tmo_before_busy", 32'(sched_busy), 1);
        @(negedge CLK);
`ifdef TX_TIMEOUT_EN
        check("tmo_err", 32'(err_timeout), 1);
        check("tmo_idle", 32'(sched_busy), 0);
`else
        check("tmo_no_err", 32'(err_timeout), 0);
        check("tmo_still_waiting", 32'(sched_busy), 1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
`endif
        model_en = 1'b1;
        a = ack_q.size(); f = frm_q.size();
        @(negedge CLK);
        req1_data = 16'h00C3; req_valid = 2'b10;
        wait_acks(a + 1, "after_tmo");
        req_valid = 2'b00;
        wait_idle("after_tmo");
        check("after_tmo_frm", 32'(frm_q[f]), 'hC3);
`ifdef TX_TIMEOUT_EN
        check("err_sticky", 32'(err_timeout), 1);
`else
        check("err_tied", 32'(err_timeout), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
